ro_measure_ctrl: RTL and testbench

- Sequencer that sits directly between the bus slave registers and the ring-oscillator partition.
- Drives the oscillator's window register (reg_0) and consumes its result register (reg_1: bit 31 go/done, bits 30:0 oscillation count).
- Runs a host-requested number of back-to-back measurements and reports sum/min/max with a valid/ack handshake.
- Synchronises reg_1, which is updated from the oscillator edge domain, into Clk.

---
 rtl/ro_measure_ctrl_if.sv | 29 ++
 rtl/ro_measure_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ro_measure_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ro_measure_ctrl_if.sv
// Signal bundle between the host register block, ro_measure_ctrl and the
// ring-oscillator partition (osc window out, osc result in, run handshake).
interface ro_measure_ctrl_if #(
  parameter int BUS_WIDTH = 32,
  parameter int SAMPLE_W  = 8
);
  logic                            start;
  logic [BUS_WIDTH-1:0]            cfg_window;
  logic [SAMPLE_W-1:0]             cfg_samples;
  logic [BUS_WIDTH-1:0]            osc_reg_0;
  logic [BUS_WIDTH-1:0]            osc_reg_1;
  logic                            busy;
  logic                            result_valid;
  logic                            result_ack;
  logic [BUS_WIDTH-2+SAMPLE_W:0]   result_sum;
  logic [BUS_WIDTH-2:0]            result_min;
  logic [BUS_WIDTH-2:0]            result_max;
  logic                            error;

  modport slave (
    input  start, cfg_window, cfg_samples, osc_reg_1, result_ack,
    output osc_reg_0, busy, result_valid, result_sum, result_min, result_max, error
  );

  modport master (
    output start, cfg_window, cfg_samples, osc_reg_1, result_ack,
    input  osc_reg_0, busy, result_valid, result_sum, result_min, result_max, error
  );
endinterface

// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator measurement sequencer: arms the oscillator window, waits for
// a synchronised done, and accumulates sum/min/max over a run of samples.
module ro_measure_ctrl #(
  parameter int                   BUS_WIDTH    = 32,
  parameter logic [BUS_WIDTH-1:0] GO_DONE_MASK = 32'h8000_0000,
  parameter int                   SAMPLE_W     = 8,
  parameter int                   CLEAR_HOLD   = 4,
  parameter int                   WD_MARGIN    = 1024
) (
  input logic              Clk,
  input logic              Reset,
  ro_measure_ctrl_if.slave bus
);

  localparam int CNT_W = BUS_WIDTH - 1;
  localparam int SUM_W = BUS_WIDTH - 1 + SAMPLE_W;
  localparam int WD_W  = BUS_WIDTH + 1;

  localparam logic [WD_W-1:0] HOLD_LAST   = WD_W'(CLEAR_HOLD - 1);
  localparam logic [WD_W-1:0] CLEAR_LIMIT = WD_W'(CLEAR_HOLD + WD_MARGIN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ARM,
    ST_WAIT_DONE,
    ST_ACCUM,
    ST_DONE,
    ST_ABORT
  } state_t;

  function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] min_u(input logic [CNT_W-1:0] cur,
                                             input logic [CNT_W-1:0] smp);
    return (smp < cur) ? smp : cur;
  endfunction

  function automatic logic [CNT_W-1:0] max_u(input logic [CNT_W-1:0] cur,
                                             input logic [CNT_W-1:0] smp);
    return (smp > cur) ? smp : cur;
  endfunction

  logic [BUS_WIDTH-1:0] osc_r1_p0, osc_r1_p1, osc_r1_p2;
  logic                 r1_stable, r1_go, done_seen, clear_seen;

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] osc0_q, osc0_d;
  logic                 busy_q, busy_d, valid_q, valid_d, error_q;
  logic [SAMPLE_W-1:0]  cnt_q, cnt_inc;
  logic [WD_W-1:0]      wd_q, wait_limit;
  logic [SUM_W-1:0]     sum_q;
  logic [CNT_W-1:0]     min_q, max_q;

  logic [BUS_WIDTH-1:0] win_q;
  logic [SAMPLE_W-1:0]  samples_q;
  logic [CNT_W-1:0]     sample_q;
  logic                 start_legal;

  // Stage p0/p1: two-flop synchroniser; p2 holds the previous p1 for the stability test
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      osc_r1_p0 <= '0;
      osc_r1_p1 <= '0;
      osc_r1_p2 <= '0;
    end else begin
      osc_r1_p0 <= bus.osc_reg_1;
      osc_r1_p1 <= osc_r1_p0;
      osc_r1_p2 <= osc_r1_p1;
    end
  end

  assign r1_stable   = (osc_r1_p1 == osc_r1_p2);
  assign r1_go       = |(osc_r1_p1 & GO_DONE_MASK);
  assign done_seen   = r1_stable & r1_go;
  assign clear_seen  = r1_stable & ~r1_go;
  assign start_legal = bus.start && (bus.cfg_window != '0) && (bus.cfg_samples != '0);
  assign cnt_inc     = cnt_q + 1'b1;
  assign wait_limit  = {1'b0, win_q} + WD_W'(WD_MARGIN);

  // Sequencer: state register and next-state/output decode
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      osc0_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      osc0_q  <= osc0_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start_legal) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (wd_q > CLEAR_LIMIT)                  state_d = ST_ABORT;
        else if (wd_q >= HOLD_LAST && clear_seen) state_d = ST_ARM;
      end
      ST_ARM:       state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done_seen)               state_d = ST_ACCUM;
        else if (wd_q > wait_limit)  state_d = ST_ABORT;
      end
      ST_ACCUM:     state_d = (cnt_inc == samples_q) ? ST_DONE : ST_CLEAR;
      ST_DONE:      if (bus.result_ack) state_d = ST_IDLE;
      ST_ABORT:     state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so the oscillator never sees decode glitches
    osc0_d  = (state_d == ST_ARM || state_d == ST_WAIT_DONE) ? win_q : '0;
    busy_d  = state_d inside {ST_CLEAR, ST_ARM, ST_WAIT_DONE, ST_ACCUM};
    valid_d = (state_d == ST_DONE);
  end

  // Run control: watchdog, sample counter, error flag and result accumulators
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      error_q <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
      sum_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wd_q <= '0;
          if (bus.start) begin
            if (start_legal) begin
              cnt_q   <= '0;
              sum_q   <= '0;
              min_q   <= '1;
              max_q   <= '0;
              error_q <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        ST_CLEAR, ST_WAIT_DONE: wd_q <= sat_inc(wd_q);
        ST_ARM:                 wd_q <= '0;
        ST_ACCUM: begin
          sum_q <= sum_q + SUM_W'(sample_q);
          min_q <= min_u(min_q, sample_q);
          max_q <= max_u(max_q, sample_q);
          cnt_q <= cnt_inc;
          wd_q  <= '0;
        end
        ST_ABORT:               error_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Data-only registers: configuration latch and captured sample
  always_ff @(posedge Clk) begin
    if (state_q == ST_IDLE && start_legal) begin
      win_q     <= bus.cfg_window;
      samples_q <= bus.cfg_samples;
    end
    if (state_q == ST_WAIT_DONE && done_seen) begin
      sample_q <= osc_r1_p1[CNT_W-1:0];
    end
  end

  assign bus.osc_reg_0    = osc0_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.result_sum   = sum_q;
  assign bus.result_min   = min_q;
  assign bus.result_max   = max_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Scoreboard bench for ro_measure_ctrl with a behavioural ring-oscillator model.
module tb_ro_measure_ctrl;

  localparam int BUS_WIDTH  = 32;
  localparam int SAMPLE_W   = 8;
  localparam int CLEAR_HOLD = 4;
  localparam int WD_MARGIN  = 1024;

  typedef struct {
    bit     is_err;
    longint sum;
    longint mn;
    longint mx;
  } exp_t;

  logic Clk;
  logic Reset;

  ro_measure_ctrl_if #(.BUS_WIDTH(BUS_WIDTH), .SAMPLE_W(SAMPLE_W)) bus ();

  ro_measure_ctrl #(
    .BUS_WIDTH   (BUS_WIDTH),
    .GO_DONE_MASK(32'h8000_0000),
    .SAMPLE_W    (SAMPLE_W),
    .CLEAR_HOLD  (CLEAR_HOLD),
    .WD_MARGIN   (WD_MARGIN)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  bit [30:0]   osc_counts[$];
  bit [30:0]   stim[$];
  logic [31:0] exp_window = '0;
  bit          glitch     = 1'b0;
  bit          never_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Oscillator: counts the window written to reg_0, then reports {done, count}
  initial begin
    int osc_st;
    int ocyc;
    bit gb;
    bit [30:0] v;
    osc_st = 0;
    ocyc   = 0;
    bus.osc_reg_1 = '0;
    forever begin
      @(posedge Clk);
      #2;
      if (Reset) begin
        osc_st = 0;
        bus.osc_reg_1 = '0;
      end else begin
        case (osc_st)
          0: begin
            bus.osc_reg_1 = '0;
            if (bus.osc_reg_0 != 0) begin
              osc_st = 1;
              ocyc   = 0;
            end
          end
          1: begin
            if (bus.osc_reg_0 == 0) begin
              osc_st = 0;
              bus.osc_reg_1 = '0;
            end else begin
              ocyc++;
              if (!never_done && longint'(ocyc) >= longint'(bus.osc_reg_0)) begin
                v = (osc_counts.size() > 0) ? osc_counts.pop_front() : 31'h0;
                bus.osc_reg_1 = {1'b1, v};
                osc_st = 2;
              end else if (glitch) begin
                gb = 1'($urandom_range(0, 1));
                bus.osc_reg_1 = {gb, 31'(ocyc * 3 + 5)};
              end else begin
                bus.osc_reg_1 = '0;
              end
            end
          end
          default: begin
            if (bus.osc_reg_0 == 0) begin
              osc_st = 0;
              bus.osc_reg_1 = '0;
            end
          end
        endcase
      end
    end
  end

  // Monitor: pops expectations on result/error events and watches hold rules
  initial begin
    bit          prev_valid, prev_ack, prev_err;
    logic [63:0] prev_sum, prev_min, prev_max;
    logic [31:0] prev_osc0;
    int          zrun;
    exp_t        e;
    prev_valid = 0; prev_ack = 0; prev_err = 0;
    prev_sum = '0; prev_min = '0; prev_max = '0; prev_osc0 = '0; zrun = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prev_valid = 0; prev_ack = 0; prev_err = 0; prev_osc0 = '0; zrun = 0;
      end else begin
        if (bus.result_valid && !prev_valid) begin
          check("result_has_expectation", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("result_kind_is_error", 64'(e.is_err), 64'd0);
            check("result_sum", 64'(bus.result_sum), e.sum);
            check("result_min", 64'(bus.result_min), e.mn);
            check("result_max", 64'(bus.result_max), e.mx);
            check("busy_at_done", 64'(bus.busy), 64'd0);
            check("osc0_at_done", 64'(bus.osc_reg_0), 64'd0);
          end
        end
        if (prev_valid && !prev_ack) begin
          check("valid_held_until_ack", 64'(bus.result_valid), 64'd1);
          check("sum_frozen", 64'(bus.result_sum), prev_sum);
          check("min_frozen", 64'(bus.result_min), prev_min);
          check("max_frozen", 64'(bus.result_max), prev_max);
        end
        if (bus.error && !prev_err) begin
          check("error_has_expectation", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("error_kind_is_error", 64'(e.is_err), 64'd1);
            check("busy_at_error", 64'(bus.busy), 64'd0);
            check("valid_at_error", 64'(bus.result_valid), 64'd0);
          end
        end
        if (bus.osc_reg_0 == 0) begin
          zrun++;
        end else begin
          if (prev_osc0 == 0) begin
            check("osc0_zero_hold_before_arm", 64'(zrun >= CLEAR_HOLD), 64'd1);
            check("osc0_arm_window", 64'(bus.osc_reg_0), 64'(exp_window));
          end
          zrun = 0;
        end
        prev_valid = bus.result_valid;
        prev_ack   = bus.result_ack;
        prev_err   = bus.error;
        prev_sum   = 64'(bus.result_sum);
        prev_min   = 64'(bus.result_min);
        prev_max   = 64'(bus.result_max);
        prev_osc0  = bus.osc_reg_0;
      end
    end
  end

  task automatic pulse_start(input logic [31:0] w, input logic [7:0] n);
    @(posedge Clk);
    #1;
    bus.cfg_window  = w;
    bus.cfg_samples = n;
    bus.start       = 1'b1;
    @(posedge Clk);
    #1;
    bus.start       = 1'b0;
    bus.cfg_window  = $urandom;
    bus.cfg_samples = 8'($urandom);
  endtask

  task automatic wait_end(input int budget, output bit got, output int cycles);
    got = 0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge Clk);
      #1;
      if (bus.result_valid || bus.error) begin
        got = 1;
        cycles = i + 1;
        break;
      end
    end
  endtask

  task automatic run_legal(input int unsigned win, input bit extra);
    exp_t      e;
    bit [30:0] mq[$];
    bit        got;
    int        cyc;
    e.is_err = 0;
    e.sum    = stim.sum() with (longint'(item));
    mq       = stim.min();
    e.mn     = longint'(mq[0]);
    mq       = stim.max();
    e.mx     = longint'(mq[0]);
    exp_q.push_back(e);
    foreach (stim[i]) osc_counts.push_back(stim[i]);
    exp_window = win;
    pulse_start(win, 8'(stim.size()));
    check("busy_after_start", 64'(bus.busy), 64'd1);
    check("error_cleared_by_start", 64'(bus.error), 64'd0);
    if (extra) begin
      repeat (5) @(posedge Clk);
      pulse_start(32'd7, 8'd1);
      check("busy_after_ignored_start", 64'(bus.busy), 64'd1);
    end
    wait_end(stim.size() * (win + 60) + 200, got, cyc);
    check("run_completed", 64'(got), 64'd1);
    if (got && bus.result_valid) begin
      repeat ($urandom_range(0, 4)) @(posedge Clk);
      #1;
      bus.result_ack = 1'b1;
      @(posedge Clk);
      #1;
      bus.result_ack = 1'b0;
      check("valid_cleared_by_ack", 64'(bus.result_valid), 64'd0);
      check("osc0_idle_after_run", 64'(bus.osc_reg_0), 64'd0);
      check("busy_idle_after_run", 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "global timeout");
  end

  initial begin
    exp_t e;
    bit   got;
    int   cyc;

    Reset = 1'b1;
    bus.start = 1'b0;
    bus.cfg_window = '0;
    bus.cfg_samples = '0;
    bus.result_ack = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_osc0", 64'(bus.osc_reg_0), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_valid", 64'(bus.result_valid), 64'd0);
    check("rst_error", 64'(bus.error), 64'd0);
    check("rst_sum", 64'(bus.result_sum), 64'd0);
    check("rst_min", 64'(bus.result_min), 64'd0);
    check("rst_max", 64'(bus.result_max), 64'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    stim = '{31'h123};
    run_legal(100, 0);

    stim = '{31'd50, 31'd20, 31'd80};
    run_legal(40, 0);

    // Oscillator never reports done: watchdog abort
    e.is_err = 1; e.sum = 0; e.mn = 0; e.mx = 0;
    exp_q.push_back(e);
    never_done = 1;
    exp_window = 32'd10;
    pulse_start(32'd10, 8'd1);
    wait_end(3000, got, cyc);
    check("watchdog_fired", 64'(got && bus.error), 64'd1);
    check("watchdog_cycle_in_range", 64'(cyc >= 10 + WD_MARGIN + 1 && cyc <= 10 + WD_MARGIN + 46), 64'd1);
    check("watchdog_busy", 64'(bus.busy), 64'd0);
    check("watchdog_valid", 64'(bus.result_valid), 64'd0);
    never_done = 0;
    repeat (3) @(posedge Clk);

    glitch = 1;
    stim = '{31'h1234, 31'h99};
    run_legal(30, 0);
    glitch = 0;

    e.is_err = 1;
    exp_q.push_back(e);
    pulse_start(32'd0, 8'd3);
    check("illegal_window_error", 64'(bus.error), 64'd1);
    check("illegal_window_busy", 64'(bus.busy), 64'd0);
    pulse_start(32'd5, 8'd0);
    repeat (2) @(posedge Clk);
    #1;
    check("illegal_samples_error", 64'(bus.error), 64'd1);
    check("illegal_samples_busy", 64'(bus.busy), 64'd0);

    stim = '{31'd777, 31'd333};
    run_legal(25, 1);

    @(posedge Clk);
    #1;
    bus.result_ack = 1'b1;
    @(posedge Clk);
    #1;
    bus.result_ack = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("idle_ack_valid", 64'(bus.result_valid), 64'd0);
    check("idle_ack_busy", 64'(bus.busy), 64'd0);

    stim = '{31'h7FFF_FFFF, 31'h0, 31'h0, 31'h7FFF_FFFF, 31'h55};
    run_legal(12, 0);

    for (int r = 0; r < 5; r++) begin
      int n;
      stim.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) stim.push_back(31'($urandom));
      run_legal($urandom_range(3, 60), 0);
    end

    // Asynchronous reset while waiting on the oscillator
    stim = '{31'h0BAD};
    exp_q.push_back(e);
    osc_counts.push_back(31'h0BAD);
    exp_window = 32'd200;
    pulse_start(32'd200, 8'd1);
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk);
      #1;
      if (bus.osc_reg_0 != 0) break;
    end
    check("reset_test_armed", 64'(bus.osc_reg_0 != 0), 64'd1);
    repeat (10) @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    check("midrun_rst_osc0", 64'(bus.osc_reg_0), 64'd0);
    check("midrun_rst_busy", 64'(bus.busy), 64'd0);
    check("midrun_rst_valid", 64'(bus.result_valid), 64'd0);
    check("midrun_rst_sum", 64'(bus.result_sum), 64'd0);
    exp_q.delete();
    osc_counts.delete();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    repeat (3) @(posedge Clk);

    stim = '{31'h4242, 31'h11};
    run_legal(50, 0);

    repeat (10) @(posedge Clk);
    check("expectations_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
